// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns load/store requests into a req/ack memory
// transaction, stalls upstream while the access is outstanding, passes ALU ops through.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] MemData_i,
  input  logic [4:0]  rd_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemReg_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] ReadData_o,
  output logic [4:0]  rd_addr_o,
  output logic [1:0]  err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      read_data_q, read_data_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             acc;
  logic             misaligned;

  assign acc        = MemRead_i | MemWrite_i;
  assign misaligned = acc & (ALUResult_i[1:0] != 2'b00);

  assign MemReg_o    = MemReg_i;
  assign ALUResult_o = ALUResult_i;
  assign rd_addr_o   = rd_addr_i;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign ReadData_o  = read_data_q;
  assign err_o       = err_q;

  // Next-state, transaction bookkeeping and stall/writeback gating.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    read_data_d = read_data_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    stall_o     = 1'b0;
    RegWrite_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!acc) begin
          RegWrite_o = RegWrite_i;
        end else if (misaligned) begin
          // Misaligned accesses are dropped without a bus cycle; only flagged.
          err_d = err_q | 2'b01;
        end else begin
          stall_o     = 1'b1;
          mem_addr_d  = {ALUResult_i[31:2], 2'b00};
          mem_wdata_d = MemData_i;
          mem_we_d    = MemWrite_i;
          mem_req_d   = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = BUSY;
        end
      end

      BUSY: begin
        stall_o = 1'b1;
        // An ack in the final allowed cycle still completes the access cleanly.
        if (mem_ack_i) begin
          if (!mem_we_q) begin
            read_data_d = mem_rdata_i;
          end else begin
            read_data_d = read_data_q;
          end
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d   = 1'b0;
          read_data_d = 32'h0000_0000;
          err_d       = err_q | 2'b10;
          timeout_d   = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        RegWrite_o = RegWrite_i & ~timeout_q;
        timeout_d  = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered memory-port/result flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      read_data_q <= 32'h0000_0000;
      err_q       <= 2'b00;
      cnt_q       <= {CNT_W{1'b0}};
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      read_data_q <= read_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage controller. It sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It turns load/store requests into a req/ack transaction on a variable-latency data-memory port, and stalls the pipeline until the access completes. Non-memory instructions pass through with zero latency.

Parameters:
TIMEOUT, 16, max cycles in BUSY without mem_ack_i before the access is abandonned (>=2)
CNT_W, 5, counter width; must hold TIMEOUT

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
RegWrite_i  in  1  from EX/MEM
MemReg_i  in  1  from EX/MEM; writeback selects memory data
MemRead_i  in  1  load request
MemWrite_i  in  1  store request
ALUResult_i  in  32  effective address / ALU result
MemData_i  in  32  store data
rd_addr_i  in  5  destination register
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  1=write, registered
mem_addr_o  out  32  word address, registered
mem_wdata_o  out  32  store data, registered
mem_ack_i  in  1  memory completion, one-cycle pulse
mem_rdata_i  in  32  read data, valid with mem_ack_i
stall_o  out  1  freeze PC/IF/ID/EX/EX-MEM
RegWrite_o  out  1  to MEM/WB
MemReg_o  out  1  to MEM/WB
ALUResult_o  out  32  to MEM/WB
ReadData_o  out  32  captured load data, registered
rd_addr_o  out  5  to MEM/WB
err_o  out  2  sticky: [0] misaligned, [1] timeout

Behaviour:
- Clock and reset: one clock (clk_i); rst_i asynchronous, active-high.
- Reset, async, also mid-transaction:
  - state=IDLE; mem_req_o, mem_we_o=0; mem_addr_o, mem_wdata_o, ReadData_o=0.
  - Counter=0; err_o=0.
  - A pending memory ack after reset is ignored.
- Access condition: acc = MemRead_i | MemWrite_i.
- Misaligned: acc & (ALUResult_i[1:0]!=0). MemWrite_i has priority if MemRead_i and MemWrite_i are both set.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - !acc: pass-through. stall_o=0; RegWrite_o=RegWrite_i; no memory activity.
  - Misaligned acc: no request issued; stall_o=0; RegWrite_o=0; err_o[0] set at the next edge.
  - Aligned acc: stall_o=1 (combinational); RegWrite_o=0.
    - At the edge: mem_addr_o={ALUResult_i[31:2],2'b00}; mem_wdata_o=MemData_i; mem_we_o=MemWrite_i; mem_req_o=1; counter=0; go to BUSY.
- BUSY:
  - stall_o=1; RegWrite_o=0; mem_req_o held at 1; address and data held stable.
  - mem_ack_i=1: if load, ReadData_o<=mem_rdata_i. mem_req_o<=0; go to DONE.
  - No ack and counter==TIMEOUT-1: mem_req_o<=0; ReadData_o<=0; err_o[1] set; timeout flag set; go to DONE.
  - Otherwise counter+1.
  - Ack and timeout in the same cycle: ack wins, no error.
  - BUSY lasts at most TIMEOUT cycles.
- DONE, exactly 1 cycle:
  - stall_o=0; RegWrite_o=RegWrite_i & ~timeout_flag; MemReg_o valid.
  - Upstream advances at this edge. Go to IDLE and clear the timeout flag.
  - The next instruction is evaluated in IDLE the following cycle.
- Combinational pass-through in all states: MemReg_o=MemReg_i; ALUResult_o=ALUResult_i; rd_addr_o=rd_addr_i. Only RegWrite_o is gated.
- Upstream holds all *_i stable while stall_o=1.
- mem_ack_i outside BUSY: ignored.
- Latency:
  - Aligned access with ack in the first BUSY cycle: IDLE, BUSY, DONE = 3 cycles, 2 of them stalled.
  - Each extra wait cycle adds 1.
- Store: ReadData_o keeps its previous value.
- err_o bits stay set until rst_i.

Test Plan:
- Reset then ALU op (RegWrite_i=1, acc=0, ALUResult_i=0x1234, rd=5) -> same cycle RegWrite_o=1, ALUResult_o=0x1234, rd_addr_o=5, stall_o=0, mem_req_o never asserted.
- Load from 0x100, memory acks 3 cycles after req with rdata 0xDEADBEEF -> mem_addr_o=0x100, mem_we_o=0; stall_o high 5 cycles; in DONE RegWrite_o=1, ReadData_o=0xDEADBEEF; mem_req_o low the cycle after ack.
- Store 0xCAFEF00D to 0x204, ack in the first BUSY cycle -> mem_we_o=1, mem_wdata_o=0xCAFEF00D, 2 stall cycles, RegWrite_o=0 throughout, ReadData_o unchanged.
- Load from 0x102 -> no mem_req_o, stall_o=0, RegWrite_o=0, err_o=2'b01 next cycle.
- Load, ack never arrives, TIMEOUT=16 -> BUSY 16 cycles; DONE with ReadData_o=0, RegWrite_o=0, err_o[1]=1; next instruction proceeds normally.
- rst_i asserted in the 2nd BUSY cycle of a load, late ack arrives after release -> mem_req_o drops immediately, state IDLE, ack ignored, ReadData_o=0, err_o=0.
